// File: rtl/calc_sequencer.sv
// Single-accumulator calculator sequencer: event at t, add/sub done at t+2, mul/div at t+WIDTH+2; events while busy are dropped.
// Define CALC_DEBOUNCE_EN to require DEB_CYCLES of stable synchronized level per button before its edge counts.
module calc_sequencer #(
  parameter int WIDTH      = 9,
  parameter int DEB_CYCLES = 16
) (
  input  logic                    clki,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] numero,
  input  logic                    enter,
  input  logic                    but_som,
  input  logic                    but_sub,
  input  logic                    but_mul,
  input  logic                    but_div,
  output logic signed [WIDTH-1:0] acc,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic                    dz,
  output logic [1:0]              op_code
);
  localparam int RW = 2 * WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic signed [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  state_t state;

  logic [4:0] btn_raw, sync1, sync2, lvl, lvl_q, evt;
  assign btn_raw = {but_div, but_mul, but_sub, but_som, enter};

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  for (genvar i = 0; i < 5; i++) begin : g_deb
    logic [DW-1:0] cnt;
    logic          stable;
    always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (sync2[i] == stable) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign lvl[i] = stable;
  end
`else
  assign lvl = sync2;
`endif

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
      evt   <= '0;
    end else begin
      lvl_q <= lvl;
      evt   <= lvl & ~lvl_q;
    end
  end

  // Fixed priority among same-cycle op events: SOM > SUB > MUL > DIV.
  logic [1:0] sel;
  always_comb begin
    sel = 2'd3;
    if (evt[1])      sel = 2'd0;
    else if (evt[2]) sel = 2'd1;
    else if (evt[3]) sel = 2'd2;
  end

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : x;
  endfunction

  logic signed [WIDTH-1:0] b;
  logic [WIDTH-1:0]        b_mag, quo, rem, rem_diff;
  logic [2*WIDTH-1:0]      prod, mcand;
  logic [CW-1:0]           cnt;
  logic                    neg, rem_ge;
  logic [WIDTH:0]          rem_sh;

  assign b_mag    = mag(b);
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, b_mag};
  assign rem_diff = rem_sh[WIDTH-1:0] - b_mag;

  logic signed [RW-1:0] res_mag, res_wide;
  always_comb begin
    res_mag = (op_code == 2'd2) ? $signed({1'b0, prod}) : $signed({{(WIDTH+1){1'b0}}, quo});
    case (op_code)
      2'd0:    res_wide = RW'(acc) + RW'(b);
      2'd1:    res_wide = RW'(acc) - RW'(b);
      default: res_wide = neg ? -res_mag : res_mag;
    endcase
  end

  logic                    sat_hi, sat_lo;
  logic signed [WIDTH-1:0] sat_val;
  assign sat_hi  = res_wide > RW'(ACC_MAX);
  assign sat_lo  = res_wide < RW'(ACC_MIN);
  assign sat_val = sat_hi ? ACC_MAX : (sat_lo ? ACC_MIN : res_wide[WIDTH-1:0]);

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      dz      <= 1'b0;
      op_code <= 2'd0;
      b       <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
      prod    <= '0;
      mcand   <= '0;
      quo     <= '0;
      rem     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (evt[0]) begin
            acc <= numero;
            ovf <= 1'b0;
            dz  <= 1'b0;
          end else if (|evt[4:1]) begin
            b       <= numero;
            op_code <= sel;
            neg     <= acc[WIDTH-1] ^ numero[WIDTH-1];
            cnt     <= '0;
            prod    <= '0;
            rem     <= '0;
            mcand   <= {{WIDTH{1'b0}}, mag(acc)};
            // quo doubles as multiplier shift register (MUL) and dividend/quotient (DIV)
            quo     <= (sel == 2'd2) ? mag(numero) : mag(acc);
            busy    <= 1'b1;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_code == 2'd3 && b == '0) begin
            dz    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (op_code[1] && cnt != CW'(WIDTH)) begin
            cnt <= cnt + 1'b1;
            if (op_code[0]) begin
              rem <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], rem_ge};
            end else begin
              if (quo[0]) prod <= prod + mcand;
              mcand <= mcand << 1;
              quo   <= quo >> 1;
            end
          end else begin
            acc   <= sat_val;
            ovf   <= ovf | sat_hi | sat_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a cycle-level behavioural model and hand-computed literal checks.
module tb_calc_sequencer;
  localparam int W = 9;

  logic clki = 1'b0;
  logic rst_n = 1'b0;
  logic signed [W-1:0] numero = '0;
  logic [4:0] btn = '0;   // {div, mul, sub, som, enter}
  logic signed [W-1:0] acc;
  logic busy, done, ovf, dz;
  logic [1:0] op_code;

  int tests = 0;
  int fails = 0;

  calc_sequencer #(.WIDTH(W), .DEB_CYCLES(16)) dut (
    .clki(clki), .rst_n(rst_n), .numero(numero),
    .enter(btn[0]), .but_som(btn[1]), .but_sub(btn[2]), .but_mul(btn[3]), .but_div(btn[4]),
    .acc(acc), .busy(busy), .done(done), .ovf(ovf), .dz(dz), .op_code(op_code)
  );

  always #5 clki = ~clki;

  // Behavioural model: events are button rises seen 3 edges late; results use plain integer arithmetic.
  int m_acc = 0, m_op = 0, cyc = 0, done_at = 0, idle_from = 0, pend_acc = 0;
  bit m_busy = 0, m_done = 0, m_ovf = 0, m_dz = 0, pend = 0, pend_ovf = 0, pend_dz = 0;
  logic [4:0] h1 = '0, h2 = '0, h3 = '0, h4 = '0, ev;
  int a, bv, r, lat_m, sel;

  always @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_op = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_dz = 0;
      pend = 0; cyc = 0; idle_from = 0;
      h1 = '0; h2 = '0; h3 = '0; h4 = '0;
    end else begin
      cyc++;
      ev = h3 & ~h4;
      h4 = h3; h3 = h2; h2 = h1; h1 = btn;
      m_done = 0;
      if (pend) begin
        if (cyc == done_at) begin
          m_acc = pend_acc; m_ovf = m_ovf | pend_ovf; m_dz = m_dz | pend_dz;
          m_done = 1; m_busy = 0; pend = 0; idle_from = cyc + 2;
        end
      end else if (cyc >= idle_from) begin
        if (ev[0]) begin
          m_acc = int'(numero); m_ovf = 0; m_dz = 0;
        end else if (ev[4:1] != 4'b0) begin
          sel = ev[1] ? 0 : ev[2] ? 1 : ev[3] ? 2 : 3;
          a = m_acc; bv = int'(numero);
          pend_dz = 0; pend_ovf = 0;
          lat_m = (sel >= 2) ? W + 1 : 1;
          case (sel)
            0: r = a + bv;
            1: r = a - bv;
            2: r = a * bv;
            default: begin
              if (bv == 0) begin pend_dz = 1; r = a; lat_m = 1; end
              else r = a / bv;
            end
          endcase
          if (r > 255) begin r = 255; pend_ovf = 1; end
          if (r < -256) begin r = -256; pend_ovf = 1; end
          pend_acc = r; pend = 1; m_busy = 1; m_op = sel; done_at = cyc + lat_m;
        end
      end
    end
  end

  always @(negedge clki) begin
    if (rst_n) begin
      tests++;
      if (int'(acc) != m_acc || busy != m_busy || done != m_done || ovf != m_ovf ||
          dz != m_dz || int'(op_code) != m_op) begin
        fails++;
        $display("FAIL model_cmp t=%0t got acc=%0d busy=%0b done=%0b ovf=%0b dz=%0b op=%0d want acc=%0d busy=%0b done=%0b ovf=%0b dz=%0b op=%0d",
                 $time, acc, busy, done, ovf, dz, op_code, m_acc, m_busy, m_done, m_ovf, m_dz, m_op);
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Press buttons for two cycles; report negedges from press to done (-1 if none in 40) and busy cycles seen.
  task automatic run_op(input logic [4:0] mask, input int val, output int lat, output int bcyc);
    lat = -1; bcyc = 0;
    @(negedge clki);
    numero = W'(val);
    btn = mask;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clki);
      if (n == 2) btn = '0;
      if (busy) bcyc++;
      if (done) begin lat = n; break; end
    end
    repeat (3) @(negedge clki);
  endtask

  task automatic load(input int val);
    @(negedge clki);
    numero = W'(val);
    btn = 5'b00001;
    repeat (2) @(negedge clki);
    btn = '0;
    repeat (5) @(negedge clki);
  endtask

  int lat, bc, ndone;

  initial begin
    repeat (2) @(negedge clki);
    check("rst_acc", int'(acc), 0);
    check("rst_flags", {busy, done, ovf, dz}, 0);
    check("rst_op", int'(op_code), 0);
    #2 rst_n = 1'b1;

    load(100);
    check("enter_100", int'(acc), 100);
    run_op(5'b00010, 27, lat, bc);
    check("som_acc", int'(acc), 127);
    check("som_lat", lat, 5);
    check("som_ovf", int'(ovf), 0);
    check("som_op", int'(op_code), 0);

    load(200);
    run_op(5'b00010, 100, lat, bc);
    check("som_sat_acc", int'(acc), 255);
    check("som_sat_ovf", int'(ovf), 1);
    load(5);
    check("enter_5_acc", int'(acc), 5);
    check("enter_clears_ovf", int'(ovf), 0);

    load(-12);
    run_op(5'b01000, 11, lat, bc);
    check("mul_acc", int'(acc), -132);
    check("mul_lat", lat, 14);
    check("mul_busy_cycles", bc, 10);
    check("mul_op", int'(op_code), 2);

    load(-256);
    run_op(5'b10000, -1, lat, bc);
    check("div_sat_acc", int'(acc), 255);
    check("div_sat_ovf", int'(ovf), 1);

    load(100);
    run_op(5'b10000, 0, lat, bc);
    check("dz_acc", int'(acc), 100);
    check("dz_flag", int'(dz), 1);
    check("dz_lat", lat, 5);
    run_op(5'b00100, 30, lat, bc);
    check("sub_after_dz", int'(acc), 70);
    check("dz_sticky", int'(dz), 1);
    load(-7);
    check("enter_clears_dz", int'(dz), 0);
    run_op(5'b10000, 2, lat, bc);
    check("div_trunc", int'(acc), -3);
    check("div_lat", lat, 14);

    load(50);
    run_op(5'b01100, 8, lat, bc);
    check("prio_acc", int'(acc), 42);
    check("prio_op", int'(op_code), 1);

    run_op(5'b00011, 7, lat, bc);
    check("enter_wins_acc", int'(acc), 7);
    check("enter_wins_no_done", lat, -1);

    // SOM pressed while a MUL is running must be dropped.
    load(3);
    @(negedge clki); numero = 9'sd5; btn = 5'b01000;
    repeat (2) @(negedge clki); btn = '0;
    repeat (3) @(negedge clki); btn = 5'b00010;
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clki);
      if (n == 2) btn = '0;
      if (done) ndone++;
    end
    check("busy_drop_acc", int'(acc), 15);
    check("busy_drop_dones", ndone, 1);

    // A held button yields exactly one event.
    load(10);
    @(negedge clki); numero = 9'sd1; btn = 5'b00010;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clki);
      if (n == 20) btn = '0;
      if (done) ndone++;
    end
    check("hold_acc", int'(acc), 11);
    check("hold_dones", ndone, 1);

    // Asynchronous reset in the middle of a multiply.
    load(-12);
    @(negedge clki); numero = 9'sd11; btn = 5'b01000;
    repeat (2) @(negedge clki); btn = '0;
    repeat (4) @(negedge clki);
    check("mid_mul_busy", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_acc", int'(acc), 0);
    check("arst_flags", {busy, done, ovf, dz}, 0);
    check("arst_op", int'(op_code), 0);
    repeat (2) @(negedge clki);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clki);
    check("post_rst_acc", int'(acc), 0);
    load(9);
    check("post_rst_enter", int'(acc), 9);

    repeat (3) @(negedge clki);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
